onehot_to_bin_pipe: RTL and testbench
=====================================

Name: onehot_to_bin_pipe

Overview:
- Multi-channel, pipelined one-hot to binary encoder with valid/ready flow control and per-channel code-validity flags.
- Successor to the combinational encoder: adds channel count, selectable multi-hot resolution mode, registered pipeline depth and backpressure.
- Sits between arbiter/grant logic and index-consuming datapaths (mux selects, FIFO pointers) where the grant vector crosses a timing boundary.

Parameters:
- OH_WIDTH, 8, one-hot code width per channel (>=1).
- BIN_WIDTH, (OH_WIDTH==1)?1:$clog2(OH_WIDTH), binary index width per channel.
- NUM_CH, 4, number of independent channels encoded in lockstep.
- PIPE_STAGES, 2, register stages from input to output (1 or 2).
- MODE, 0, multi-hot resolution: 0 = OR of set indices, 1 = lowest set index, 2 = highest set index.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_onehot  input  NUM_CH*OH_WIDTH  channel c at bits [c*OH_WIDTH +: OH_WIDTH].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts beat.
- out_bin  output  NUM_CH*BIN_WIDTH  channel c index at [c*BIN_WIDTH +: BIN_WIDTH].
- out_zero  output  NUM_CH  channel c input was all-zero.
- out_multi  output  NUM_CH  channel c input had >=2 bits set.

Behaviour:
- Reset: out_valid=0, out_bin=0, out_zero=0, out_multi=0, all stage valids cleared; in_ready=1 from the first cycle after reset deasserts. Reset mid-transfer discards all in-flight beats. There is no partial output.
- Transfer occurs on a cycle where valid && ready at that interface.
- Stage rule: each stage holds valid_q. It loads when !valid_q || downstream_ready. in_ready = !valid_q[0] || ready_into_stage1 (combinational ready chain, no bubble). Full throughput is 1 beat/cycle.
- Latency: PIPE_STAGES cycles from input handshake to out_valid with out_ready held 1.
- PIPE_STAGES=1: encode is combinational from the input, and result, zero and multi flags are registered.
- PIPE_STAGES=2: stage 1 registers raw in_onehot. Stage 2 registers encoded result and flags.
- Backpressure: out_ready=0 with out_valid=1 holds out_bin/out_zero/out_multi stable until accepted. Upstream stalls once all stages are full. No beat is lost or duplicated.
- Encode per channel:
  - Exactly one bit i set: bin=i, zero=0, multi=0.
  - All zero: bin=0, zero=1, multi=0.
  - Multi-hot: multi=1, and bin depends on MODE. MODE 0 gives bitwise OR of all set indices. MODE 1 gives lowest set index. MODE 2 gives highest set index.
- OH_WIDTH=1: bin always 0. zero=~in. multi never set.
- Indices are truncated to BIN_WIDTH. Widths are exact with no sign extension.
- Channels are fully independent. Flags never affect the handshake, so error beats flow like valid beats.
- Data registers need not reset; valid registers must.

Optional Feature:
- Macro ONEHOT_TO_BIN_ERR_CNT_EN.
- With the macro defined: adds output err_cnt [15:0] and input err_clr [1].
  - err_cnt increments by the count of channels with zero|multi set, on each output handshake. It saturates at 16'hFFFF.
  - err_clr=1 zeroes it next cycle, taking priority over a same-cycle increment.
  - rst clears err_cnt.
- Without the macro: the ports and counter are absent, and the datapath is otherwise identical.

Test Plan:
- NUM_CH=4, OH_WIDTH=8, PIPE_STAGES=2, out_ready=1. Drive in_onehot={8'h80,8'h01,8'h10,8'h04}. Expect out_valid 2 cycles later, out_bin={3'd7,3'd0,3'd4,3'd2}, zero=0, multi=0.
- Channel 0 = 8'h00. Expect ch0 bin=0, out_zero[0]=1, other channels unaffected.
- Channel 0 = 8'h14 (bits 2,4). Expect MODE0 bin=6, MODE1 bin=2, MODE2 bin=4, with out_multi[0]=1 in every mode.
- Stream 6 back-to-back beats with out_ready low for cycles 3-5. Expect in_ready low after stages fill, then all 6 outputs in order with no loss or duplication, each held stable while stalled.
- Assert rst with 2 beats in flight. Expect out_valid=0 next cycle and no stale beat after release. With ONEHOT_TO_BIN_ERR_CNT_EN defined, expect err_cnt=0.
- With ONEHOT_TO_BIN_ERR_CNT_EN defined, send 3 beats each having 2 bad channels. Expect err_cnt=6. Pulse err_clr in the same cycle as a 4th bad beat and expect err_cnt=0.

Source files
------------

// File: rtl/onehot_to_bin_pipe.sv
// Multi-channel pipelined one-hot to binary encoder with zero/multi-hot flags per channel.
// Latency: PIPE_STAGES cycles (1 or 2) from input handshake to out_valid.
// Backpressure: combinational ready chain, 1 beat/cycle, stalls upstream when all stages full.
// Optional: define ONEHOT_TO_BIN_ERR_CNT_EN to add err_cnt/err_clr (saturating bad-channel counter).
module onehot_to_bin_pipe #(
   parameter int OH_WIDTH    = 8,
   parameter int BIN_WIDTH   = (OH_WIDTH == 1) ? 1 : $clog2(OH_WIDTH),
   parameter int NUM_CH      = 4,
   parameter int PIPE_STAGES = 2,
   parameter int MODE        = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUM_CH*OH_WIDTH-1:0]    in_onehot,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUM_CH*BIN_WIDTH-1:0]   out_bin,
   output logic [NUM_CH-1:0]             out_zero,
   output logic [NUM_CH-1:0]             out_multi
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
   ,
   input  logic                          err_clr,
   output logic [15:0]                   err_cnt
`endif
);

   // Source feeding the encoder: raw input (1 stage) or stage-1 register (2 stages)
   logic [NUM_CH*OH_WIDTH-1:0]  enc_src;
   logic                        src_valid;
   logic                        src_ready;

   logic [NUM_CH*BIN_WIDTH-1:0] enc_bin;
   logic [NUM_CH-1:0]           enc_zero;
   logic [NUM_CH-1:0]           enc_multi;

   // Per-channel scratch for the encoder scan
   logic [BIN_WIDTH-1:0]        idx_or;
   logic [BIN_WIDTH-1:0]        idx_lo;
   logic [BIN_WIDTH-1:0]        idx_hi;
   logic                        seen_one;
   logic                        seen_two;

   // The output stage can load when empty or when its beat is leaving this cycle
   assign src_ready = !out_valid || out_ready;

   generate
      if (PIPE_STAGES == 1) begin : g_one_stage
         assign enc_src   = in_onehot;
         assign src_valid = in_valid;
         assign in_ready  = src_ready;
      end else begin : g_two_stage
         logic                       s1_valid;
         logic [NUM_CH*OH_WIDTH-1:0] s1_onehot;

         assign enc_src   = s1_onehot;
         assign src_valid = s1_valid;
         assign in_ready  = !s1_valid || src_ready;

         // Stage-1 valid: advances whenever the stage can accept
         always_ff @(posedge clk) begin
            if (rst)
               s1_valid <= 1'b0;
            else if (in_ready)
               s1_valid <= in_valid;
         end

         // Stage-1 raw code capture; data needs no reset
         always_ff @(posedge clk) begin
            if (in_ready && in_valid)
               s1_onehot <= in_onehot;
         end
      end
   endgenerate

   // Encode every channel: OR / lowest / highest set index plus zero and multi-hot flags
   always_comb begin
      enc_bin   = '0;
      enc_zero  = '0;
      enc_multi = '0;
      idx_or    = '0;
      idx_lo    = '0;
      idx_hi    = '0;
      seen_one  = 1'b0;
      seen_two  = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         idx_or   = '0;
         idx_lo   = '0;
         idx_hi   = '0;
         seen_one = 1'b0;
         seen_two = 1'b0;
         for (int i = 0; i < OH_WIDTH; i++) begin
            if (enc_src[c*OH_WIDTH + i]) begin
               idx_or = idx_or | BIN_WIDTH'(i);
               if (!seen_one)
                  idx_lo = BIN_WIDTH'(i);
               idx_hi = BIN_WIDTH'(i);
               if (seen_one)
                  seen_two = 1'b1;
               seen_one = 1'b1;
            end
         end
         enc_zero[c]  = !seen_one;
         enc_multi[c] = seen_two;
         // With a single bit set all three resolutions agree, so MODE only matters for multi-hot
         if (MODE == 1)
            enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = idx_lo;
         else if (MODE == 2)
            enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = idx_hi;
         else
            enc_bin[c*BIN_WIDTH +: BIN_WIDTH] = idx_or;
      end
   end

   // Output stage: registered index and flags, held while downstream stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_bin   <= '0;
         out_zero  <= '0;
         out_multi <= '0;
      end else if (src_ready) begin
         out_valid <= src_valid;
         if (src_valid) begin
            out_bin   <= enc_bin;
            out_zero  <= enc_zero;
            out_multi <= enc_multi;
         end
      end
   end

`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
   logic [16:0] err_add;
   logic [16:0] err_sum;

   // Number of bad channels in the beat currently presented at the output
   always_comb begin
      err_add = '0;
      for (int c = 0; c < NUM_CH; c++)
         err_add = err_add + 17'(out_zero[c] | out_multi[c]);
      err_sum = {1'b0, err_cnt} + err_add;
   end

   // Saturating error counter; clear wins over a same-cycle increment
   always_ff @(posedge clk) begin
      if (rst)
         err_cnt <= '0;
      else if (err_clr)
         err_cnt <= '0;
      else if (out_valid && out_ready)
         err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
   end
`endif

endmodule

// File: tb/tb_onehot_to_bin_pipe.sv
// Directed bench for onehot_to_bin_pipe: three instances (MODE 0/1/2) share one stimulus.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_onehot_to_bin_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_onehot;

   logic        in_ready0, in_ready1, in_ready2;
   logic        out_valid0, out_valid1, out_valid2;
   logic [11:0] out_bin0, out_bin1, out_bin2;
   logic [3:0]  out_zero0, out_zero1, out_zero2;
   logic [3:0]  out_multi0, out_multi1, out_multi2;
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
   logic        err_clr;
   logic [15:0] err_cnt0, err_cnt1, err_cnt2;
`endif

   int checks = 0;
   int errors = 0;

   onehot_to_bin_pipe #(.OH_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(2), .MODE(0)) u_mode0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_onehot(in_onehot),
      .out_valid(out_valid0), .out_ready(out_ready), .out_bin(out_bin0),
      .out_zero(out_zero0), .out_multi(out_multi0)
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      , .err_clr(err_clr), .err_cnt(err_cnt0)
`endif
   );

   onehot_to_bin_pipe #(.OH_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(2), .MODE(1)) u_mode1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_onehot(in_onehot),
      .out_valid(out_valid1), .out_ready(out_ready), .out_bin(out_bin1),
      .out_zero(out_zero1), .out_multi(out_multi1)
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      , .err_clr(err_clr), .err_cnt(err_cnt1)
`endif
   );

   onehot_to_bin_pipe #(.OH_WIDTH(8), .NUM_CH(4), .PIPE_STAGES(2), .MODE(2)) u_mode2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_onehot(in_onehot),
      .out_valid(out_valid2), .out_ready(out_ready), .out_bin(out_bin2),
      .out_zero(out_zero2), .out_multi(out_multi2)
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      , .err_clr(err_clr), .err_cnt(err_cnt2)
`endif
   );

   // Advance one clock, landing on the next falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive one beat and step to the cycle where its result is visible (2 stages)
   task automatic push_and_wait(input logic [31:0] vec);
      in_onehot = vec;
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      in_onehot = '0;
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      err_clr   = 1'b0;
`endif
      @(negedge clk);
      tick();
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid0); end
      checks++;
      if (out_bin0 !== 12'h000) begin errors++; $display("FAIL reset_out_bin got %h want 000", out_bin0); end
      checks++;
      if (out_zero0 !== 4'b0000 || out_multi0 !== 4'b0000) begin
         errors++; $display("FAIL reset_flags got zero=%b multi=%b want 0000/0000", out_zero0, out_multi0);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (in_ready0 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready0); end
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      checks++;
      if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt0); end
`endif
      @(negedge clk);
   endtask

   task automatic test_onehot();
      in_onehot = {8'h80, 8'h01, 8'h10, 8'h04};
      in_valid  = 1'b1;
      tick();
      in_valid  = 1'b0;
      checks++;
      if (out_valid0 !== 1'b0) begin errors++; $display("FAIL onehot_early_valid got %b want 0", out_valid0); end
      tick();
      checks++;
      if (out_valid0 !== 1'b1) begin errors++; $display("FAIL onehot_latency got %b want 1", out_valid0); end
      checks++;
      if (out_bin0 !== 12'b111_000_100_010) begin
         errors++; $display("FAIL onehot_bin got %b want 111000100010", out_bin0);
      end
      checks++;
      if (out_zero0 !== 4'b0000 || out_multi0 !== 4'b0000) begin
         errors++; $display("FAIL onehot_flags got zero=%b multi=%b want 0000/0000", out_zero0, out_multi0);
      end
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin errors++; $display("FAIL onehot_dup got valid=%b want 0", out_valid0); end
   endtask

   task automatic test_zero();
      push_and_wait({8'h80, 8'h01, 8'h10, 8'h00});
      checks++;
      if (out_bin0 !== 12'b111_000_100_000) begin
         errors++; $display("FAIL zero_bin got %b want 111000100000", out_bin0);
      end
      checks++;
      if (out_zero0 !== 4'b0001 || out_multi0 !== 4'b0000) begin
         errors++; $display("FAIL zero_flags got zero=%b multi=%b want 0001/0000", out_zero0, out_multi0);
      end
      tick();
   endtask

   task automatic test_multi();
      // ch3 = all ones, ch0 = bits 2 and 4
      push_and_wait({8'hFF, 8'h01, 8'h10, 8'h14});
      checks++;
      if (out_bin0 !== 12'b111_000_100_110) begin
         errors++; $display("FAIL multi_mode0_bin got %b want 111000100110", out_bin0);
      end
      checks++;
      if (out_bin1 !== 12'b000_000_100_010) begin
         errors++; $display("FAIL multi_mode1_bin got %b want 000000100010", out_bin1);
      end
      checks++;
      if (out_bin2 !== 12'b111_000_100_100) begin
         errors++; $display("FAIL multi_mode2_bin got %b want 111000100100", out_bin2);
      end
      checks++;
      if (out_multi0 !== 4'b1001 || out_multi1 !== 4'b1001 || out_multi2 !== 4'b1001) begin
         errors++; $display("FAIL multi_flags got %b/%b/%b want 1001", out_multi0, out_multi1, out_multi2);
      end
      checks++;
      if (out_zero0 !== 4'b0000) begin errors++; $display("FAIL multi_zero got %b want 0000", out_zero0); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] vecs [6];
      logic [11:0] exp_bin [6];
      int sent = 0;
      int rcv = 0;
      int cyc = 0;
      bit saw_stall = 0;
      bit fire_in, fire_out;
      for (int k = 0; k < 6; k++) begin
         for (int c = 0; c < 4; c++) begin
            vecs[k][c*8 +: 8]    = 8'(1 << ((k + c) % 8));
            exp_bin[k][c*3 +: 3] = 3'((k + c) % 8);
         end
      end
      while (rcv < 6 && cyc < 40) begin
         out_ready = !(cyc >= 3 && cyc <= 5);
         in_valid  = (sent < 6);
         if (sent < 6) in_onehot = vecs[sent];
         else          in_onehot = '0;
         #1;
         if (!in_ready0) saw_stall = 1;
         if (out_valid0) begin
            checks++;
            if (out_bin0 !== exp_bin[rcv]) begin
               errors++; $display("FAIL b2b_beat%0d cyc%0d got %b want %b", rcv, cyc, out_bin0, exp_bin[rcv]);
            end
         end
         fire_in  = in_valid && in_ready0;
         fire_out = out_valid0 && out_ready;
         @(posedge clk);
         if (fire_in)  sent++;
         if (fire_out) rcv++;
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (rcv != 6 || sent != 6) begin errors++; $display("FAIL b2b_count got sent=%0d rcv=%0d want 6/6", sent, rcv); end
      checks++;
      if (!saw_stall) begin errors++; $display("FAIL b2b_stall got in_ready never low want a stall"); end
      #1;
      checks++;
      if (out_valid0 !== 1'b0) begin errors++; $display("FAIL b2b_extra_beat got valid=%b want 0", out_valid0); end
      @(negedge clk);
   endtask

   task automatic test_reset_midflight();
      out_ready = 1'b0;
      in_onehot = {8'h01, 8'h00, 8'h02, 8'h04};
      in_valid  = 1'b1;
      tick();
      in_onehot = {8'h02, 8'h04, 8'h08, 8'h10};
      tick();
      in_valid  = 1'b0;
      rst       = 1'b1;
      tick();
      checks++;
      if (out_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid0); end
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      checks++;
      if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL midrst_err_cnt got %0d want 0", err_cnt0); end
`endif
      rst       = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         checks++;
         if (out_valid0 !== 1'b0) begin errors++; $display("FAIL midrst_stale cyc%0d got valid=%b want 0", k, out_valid0); end
      end
   endtask

`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
   task automatic test_err_cnt();
      // ch2 all-zero and ch1 multi-hot: two bad channels per beat
      in_onehot = {8'h80, 8'h00, 8'h14, 8'h04};
      out_ready = 1'b1;
      in_valid  = 1'b1;
      repeat (3) tick();
      in_valid  = 1'b0;
      repeat (3) tick();
      checks++;
      if (err_cnt0 !== 16'd6) begin errors++; $display("FAIL errcnt_accum got %0d want 6", err_cnt0); end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      checks++;
      if (out_valid0 !== 1'b1) begin errors++; $display("FAIL errcnt_beat4_valid got %b want 1", out_valid0); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      checks++;
      if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL errcnt_clr got %0d want 0", err_cnt0); end
      tick();
      checks++;
      if (err_cnt0 !== 16'd0) begin errors++; $display("FAIL errcnt_after_clr got %0d want 0", err_cnt0); end
   endtask
`endif

   initial begin
      test_reset();
      test_onehot();
      test_zero();
      test_multi();
      test_back_to_back();
      test_reset_midflight();
`ifdef ONEHOT_TO_BIN_ERR_CNT_EN
      test_err_cnt();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout got no finish want finish");
      $fatal(1, "watchdog");
   end

endmodule
